// File: rtl/uart_rx_control.sv
// Reassembles two received UART bytes (low first) into a 16-bit word with an inter-byte timeout.
// Define RX_TIMEOUT_EN to build the timeout counter and TIMEOUT state; otherwise GOT_LOW waits forever.
module uart_rx_control #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        timeout_err,
    output logic [7:0]  word_count,
    output logic [1:0]  stateID
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_LOW = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_rx_control: TIMEOUT_CYCLES must be >= 2");
    end

    state_t     state;
    state_t     state_next;
    logic [7:0] low_byte;
    logic       capture_low;
    logic       complete_word;

`ifdef RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             expire;
    logic             timeout_flag;
`endif

    always_comb begin
        state_next    = state;
        capture_low   = 1'b0;
        complete_word = 1'b0;
`ifdef RX_TIMEOUT_EN
        expire        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_ready) begin
                    capture_low = 1'b1;
                    state_next  = GOT_LOW;
                end
            end
            GOT_LOW: begin
                // A high byte arriving on the expiry cycle still completes the word.
                if (rx_ready) begin
                    complete_word = 1'b1;
                    state_next    = DONE;
                end
`ifdef RX_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    expire     = 1'b1;
                    state_next = TIMEOUT;
                end
`endif
            end
            DONE, TIMEOUT: begin
                if (rx_ready) begin
                    capture_low = 1'b1;
                    state_next  = GOT_LOW;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_byte   <= 8'h00;
            data_out   <= 16'h0000;
            data_valid <= 1'b0;
            word_count <= 8'h00;
        end else begin
            data_valid <= complete_word;
            if (capture_low) begin
                low_byte <= rx_data;
            end
            if (complete_word) begin
                data_out   <= {rx_data, low_byte};
                word_count <= word_count + 8'd1;
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    // Cleared on every GOT_LOW entry, so the count tops out at TIMEOUT_CYCLES and never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (capture_low) begin
                tmo_cnt <= '0;
            end else if (state == GOT_LOW) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (complete_word) begin
                timeout_flag <= 1'b0;
            end else if (expire) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_flag;
`else
    assign timeout_err = 1'b0;
`endif

    assign stateID = state;

endmodule
